// File: rtl/i2s_tx_pkg.sv
// Shared I2S definitions: channel encoding on ws and frame geometry helpers.
// The receive path imports the same package so both ends agree on framing.
package i2s_tx_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ws_e;

  function automatic int unsigned frame_len(input int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned dw);
    return $clog2(2 * dw);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-source handshake plus serial outputs of the I2S transmitter.
// The source drives through master; the transmitter uses slave.
interface i2s_tx_if
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              en;
  logic [DATA_W-1:0] left_in;
  logic [DATA_W-1:0] right_in;
  logic              valid;
  logic              ready;
  logic              ws;
  logic              sd;
  logic              frame_st;
  logic              underrun;

  modport master (
    output en, left_in, right_in, valid,
    input  ready, ws, sd, frame_st, underrun
  );

  modport slave (
    input  en, left_in, right_in, valid,
    output ready, ws, sd, frame_st, underrun
  );
endinterface

// File: rtl/i2s_tx_buf.sv
// One-entry holding register between the sample source and the frame shifter.
// Updates on the falling sck edge, like the rest of the transmitter.
module i2s_tx_buf #(
  parameter int unsigned W = 32
) (
  input  logic         sck_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  assign accept = valid_i && !full_q;

  // Accept only happens while empty and pop only matters while full, so they never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(negedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;
endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: frame counter, frame shifter and registered
// ws/sd/frame_st/underrun outputs, all updated on the falling edge of sck.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic     sck,
  input logic     rst,
  i2s_tx_if.slave bus
);
  localparam int unsigned FRAME_LEN = frame_len(DATA_W);
  localparam int unsigned CNT_W     = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(FRAME_LEN - 2);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  ws_e                  ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic                 fs_q, fs_d;
  logic                 ur_q, ur_d;

  logic                 advance;
  logic                 load;
  logic                 buf_full;
  logic [FRAME_LEN-1:0] buf_data;

  i2s_tx_buf #(.W(FRAME_LEN)) u_buf (
    .sck_i   (sck),
    .rst_i   (rst),
    .valid_i (bus.valid),
    .data_i  ({bus.left_in, bus.right_in}),
    .ready_o (bus.ready),
    .pop_i   (load),
    .full_o  (buf_full),
    .data_o  (buf_data)
  );

  // The counter parks on the last period when en is low, so a frame always completes.
  assign advance = bus.en || (cnt_q != CNT_LAST);
  assign load    = advance && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ws_d    = CH_LEFT;
    sd_d    = 1'b0;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    if (advance) begin
      cnt_d = load ? '0 : cnt_q + 1'b1;
      if (cnt_d >= WS_FIRST && cnt_d <= WS_LAST) begin
        ws_d = CH_RIGHT;
      end
      if (load) begin
        // An empty buffer sends a silent frame; no bypass from the input pair.
        shift_d = buf_full ? {buf_data[FRAME_LEN-2:0], 1'b0} : '0;
        sd_d    = buf_full && buf_data[FRAME_LEN-1];
        fs_d    = 1'b1;
        ur_d    = !buf_full;
      end else begin
        sd_d    = shift_q[FRAME_LEN-1];
        shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge sck or posedge rst) begin
    if (rst) begin
      cnt_q   <= CNT_LAST;
      shift_q <= '0;
      ws_q    <= CH_LEFT;
      sd_q    <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign bus.ws       = ws_q;
  assign bus.sd       = sd_q;
  assign bus.frame_st = fs_q;
  assign bus.underrun = ur_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-level reference model, per-cycle compare,
// serial decoder against the accepted-pair queue, and directed literal checks.
module tb_i2s_tx;
  localparam int DW = 16;
  localparam int FL = 2 * DW;

  logic sck = 1'b0;
  logic rst = 1'b0;

  i2s_tx_if #(.DATA_W(DW)) bus ();
  i2s_tx #(.DATA_W(DW)) dut (.sck(sck), .rst(rst), .bus(bus));

  always #50 sck = ~sck;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: period index, parked flag, current frame, holding buffer.
  int            m_k     = FL - 1;
  bit            m_park  = 1'b1;
  bit            m_uflag = 1'b0;
  logic [FL-1:0] m_frame = '0;
  logic [FL-1:0] m_buf[$];
  logic [FL-1:0] acc_q[$];
  bit            m_acc;

  always @(negedge sck or posedge rst) begin
    if (rst) begin
      m_k     = FL - 1;
      m_park  = 1'b1;
      m_uflag = 1'b0;
      m_frame = '0;
      m_buf.delete();
      acc_q.delete();
    end else begin
      m_acc = (bus.valid === 1'b1) && (m_buf.size() == 0);
      if (bus.en === 1'b1 || m_k != FL - 1) begin
        m_park = 1'b0;
        m_k    = (m_k + 1) % FL;
        if (m_k == 0) begin
          if (m_buf.size() != 0) begin
            m_frame = m_buf.pop_front();
            m_uflag = 1'b0;
          end else begin
            m_frame = '0;
            m_uflag = 1'b1;
          end
        end
      end else begin
        m_park = 1'b1;
      end
      if (m_acc) begin
        m_buf.push_back({bus.left_in, bus.right_in});
        acc_q.push_back({bus.left_in, bus.right_in});
      end
    end
  end

  function automatic logic [4:0] model_out();
    logic w, s, f, u, r;
    w = !m_park && (m_k >= DW - 1) && (m_k <= FL - 2);
    s = m_park ? 1'b0 : m_frame[FL-1-m_k];
    f = !m_park && (m_k == 0);
    u = f && m_uflag;
    r = (m_buf.size() == 0);
    return {w, s, f, u, r};
  endfunction

  always @(posedge sck) begin
    if (chk_on) begin
      logic [4:0] got, exp;
      got = {bus.ws, bus.sd, bus.frame_st, bus.underrun, bus.ready};
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t k=%0d ws/sd/fs/ur/rdy got=%b exp=%b", $time, m_k, got, exp);
      end
    end
  end

  // Serial decoder: rebuild each non-silent frame and match it to the accept order.
  int            rx_n   = 0;
  bit            rx_on  = 1'b0;
  bit            rx_ur  = 1'b0;
  int            rx_got = 0;
  logic [FL-1:0] rx_sh  = '0;
  logic [FL-1:0] rx_first = '0;
  logic [FL-1:0] rx_exp;

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      rx_on = 1'b0;
      rx_n  = 0;
    end else begin
      if (bus.frame_st === 1'b1) begin
        rx_on = 1'b1;
        rx_n  = 0;
        rx_ur = bus.underrun;
      end
      if (rx_on) begin
        rx_sh = {rx_sh[FL-2:0], bus.sd};
        rx_n++;
        if (rx_n == FL) begin
          rx_on = 1'b0;
          if (!rx_ur) begin
            checks++;
            if (acc_q.size() == 0) begin
              errors++;
              $display("FAIL rx_pair got=%h exp=<none accepted>", rx_sh);
            end else begin
              rx_exp = acc_q.pop_front();
              if (rx_sh !== rx_exp) begin
                errors++;
                $display("FAIL rx_pair got=%h exp=%h", rx_sh, rx_exp);
              end
            end
            if (rx_got == 0) rx_first = rx_sh;
            rx_got++;
          end
        end
      end
    end
  end

  int ur_cnt = 0;
  always @(posedge sck) if (bus.underrun === 1'b1) ur_cnt++;

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at posedge+5; returns at posedge+5 of the period after the accepting edge.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    bit rd;
    n = 0;
    bus.valid    = 1'b1;
    bus.left_in  = l;
    bus.right_in = r;
    forever begin
      rd = bus.ready;
      @(negedge sck);
      @(posedge sck);
      #5;
      if (rd) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got=no_accept exp=accept");
        break;
      end
    end
  endtask

  task automatic wait_period(input int k);
    int n;
    n = 0;
    do begin
      @(posedge sck);
      n++;
    end while (!(!m_park && m_k == k) && n < 500);
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_period_%0d got=timeout exp=reached", k);
    end
    #5;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, first, bad, ur0, base, idle;
    bus.en = 1'b0; bus.valid = 1'b0; bus.left_in = '0; bus.right_in = '0;
    #2 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge sck);
    #5;
    check1("reset_state", {bus.ws, bus.sd, bus.ready, bus.frame_st, bus.underrun}, 5'b00100);

    // 1: first frame silent with underrun, second carries A5F0/0F0F
    rst = 1'b0;
    bus.en = 1'b1;
    send(16'hA5F0, 16'h0F0F);
    bus.valid = 1'b0;
    check1("frame1_underrun", {bus.frame_st, bus.underrun}, 2'b11);
    wait_period(0);
    check1("frame2_start", {bus.frame_st, bus.underrun, bus.sd}, 3'b101);
    ones = 0; first = -1;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) begin @(posedge sck); #5; end
      if (bus.ws === 1'b1) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    check1("ws_ones", ones, 16);
    check1("ws_first", first, 15);
    check1("frame2_data", rx_first, 32'hA5F00F0F);

    // 2: continuous valid with incrementing pairs
    wait_period(2);
    ur0 = ur_cnt;
    for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    bus.valid = 1'b0;
    wait_period(0);
    check1("stream_underruns", ur_cnt - ur0, 0);

    // 3: pair offered exactly on the load edge with the buffer empty
    wait_period(31);
    send(16'hC3C3, 16'h3C3C);
    bus.valid = 1'b0;
    check1("load_edge_underrun", {bus.frame_st, bus.underrun}, 2'b11);

    // 4: drop en mid-frame, frame completes, then parks quietly
    send(16'h8001, 16'h0001);
    bus.valid = 1'b0;
    wait_period(0);
    wait_period(20);
    bus.en = 1'b0;
    wait_period(31);
    check1("right_lsb", {bus.ws, bus.sd}, 2'b01);
    bad = 0;
    repeat (40) begin
      @(posedge sck); #5;
      if ({bus.ws, bus.sd, bus.frame_st} !== 3'b000) bad++;
    end
    check1("parked_quiet", bad, 0);
    bus.en = 1'b1;
    @(posedge sck); #5;
    check1("rearm_frame_st", bus.frame_st, 1'b1);

    // 5: reset mid-frame with the buffer full
    send(16'h1234, 16'h5678);
    bus.valid = 1'b0;
    wait_period(9);
    check1("pre_rst_ready", bus.ready, 1'b0);
    rst = 1'b1;
    #1;
    check1("rst_outputs", {bus.ws, bus.sd, bus.ready, bus.frame_st, bus.underrun}, 5'b00100);
    @(posedge sck); @(posedge sck); #5;
    rst = 1'b0;
    @(posedge sck); #5;
    check1("post_rst_underrun", {bus.frame_st, bus.underrun}, 2'b11);

    // 6: random pairs with random gaps, decoded bit-exactly
    repeat (80) @(posedge sck);
    #5;
    base = rx_got;
    for (int i = 0; i < 64; i++) begin
      send(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        bus.valid = 1'b0;
        idle = $urandom_range(0, 40);
        if (idle > 0) begin
          repeat (idle) @(posedge sck);
          #5;
        end
      end
    end
    bus.valid = 1'b0;
    repeat (100) @(posedge sck);
    #5;
    check1("random_pairs_rx", rx_got - base, 64);
    check1("acc_queue_empty", acc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
